// File: rtl/cifra_pkg.sv
// Shared AES-128 definitions for the iterative cipher: sizes, controller states,
// S-box and the byte-level round helpers used by the combinational datapath.
package cifra_pkg;

    localparam int NBLOCO     = 128;
    localparam int NCHAVE_EXP = 1280;
    localparam int NRODADAS   = 10;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        RODADA = 2'd1,
        FINAL  = 2'd2,
        SAIDA  = 2'd3
    } estado_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [NBLOCO-1:0] sub_shift(input logic [NBLOCO-1:0] s);
        logic [NBLOCO-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [NBLOCO-1:0] mix_columns(input logic [NBLOCO-1:0] s);
        logic [NBLOCO-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Round key r lands at [128*(10-r) +: 128], so round 1 occupies the top bits.
    function automatic logic [NCHAVE_EXP-1:0] expande_chave(input logic [NBLOCO-1:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [NCHAVE_EXP-1:0] e;
        rc = 8'h01;
        e  = '0;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox(t[23:16]) ^ rc, sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 1; r <= NRODADAS; r++) begin
            e[NBLOCO*(NRODADAS-r) +: NBLOCO] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return e;
    endfunction

    function automatic logic [NBLOCO-1:0] chave_rodada(input logic [NCHAVE_EXP-1:0] expandida,
                                                       input logic [3:0] r);
        int idx;
        if (r == 4'd0 || r > 4'd10) return '0;
        idx = NRODADAS - int'(r);
        return expandida[NBLOCO*idx +: NBLOCO];
    endfunction

endpackage

// File: rtl/controle_cifra_iterativa_rodada_final.sv
// Last AES round: SubBytes, ShiftRows and AddRoundKey, without MixColumns.
module rodada_final
    import cifra_pkg::*;
(
    input  logic [NBLOCO-1:0] estado_i,
    input  logic [NBLOCO-1:0] chave_i,
    output logic [NBLOCO-1:0] estado_o
);

    assign estado_o = sub_shift(estado_i) ^ chave_i;

endmodule

// File: rtl/expandeChave.sv
// Combinational AES-128 key schedule producing round keys 1..10 from the cipher key.
module expandeChave
    import cifra_pkg::*;
(
    input  logic [NBLOCO-1:0]     chave_i,
    output logic [NCHAVE_EXP-1:0] chaveExpandida_o
);

    assign chaveExpandida_o = expande_chave(chave_i);

endmodule

// File: rtl/mioloCifraBloco.sv
// One full middle AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module mioloCifraBloco
    import cifra_pkg::*;
(
    input  logic [NBLOCO-1:0]     estado_i,
    input  logic [NCHAVE_EXP-1:0] chaveExpandida_i,
    input  logic [3:0]            rodada_i,
    output logic [NBLOCO-1:0]     estado_o
);

    assign estado_o = mix_columns(sub_shift(estado_i)) ^ chave_rodada(chaveExpandida_i, rodada_i);

endmodule

// File: rtl/controle_cifra_iterativa.sv
// Iterative AES-128 encryption controller: one round per clock over a shared
// combinational round datapath, with valid/ready handshakes on both sides.
module controle_cifra_iterativa #(
    parameter int NRODADAS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ent_valid,
    output logic         ent_ready,
    input  logic [127:0] bloco,
    input  logic [127:0] chave,
    input  logic         cancela,
    output logic         sai_valid,
    input  logic         sai_ready,
    output logic [127:0] saida,
    output logic         ocupado,
    output logic [3:0]   rodada_atual
);
    import cifra_pkg::estado_t;
    import cifra_pkg::OCIOSO;
    import cifra_pkg::RODADA;
    import cifra_pkg::FINAL;
    import cifra_pkg::SAIDA;
    import cifra_pkg::chave_rodada;

    generate
        if (NRODADAS != cifra_pkg::NRODADAS) begin : g_nrodadas_invalido
            $error("controle_cifra_iterativa supports only NRODADAS = 10 (AES-128)");
        end
    endgenerate

    estado_t        fsm_q, fsm_d;
    logic [127:0]   estado_q, estado_d;
    logic [127:0]   chave_q, chave_d;
    logic [127:0]   saida_q, saida_d;
    logic           sai_valid_q, sai_valid_d;
    logic [3:0]     rodada_q, rodada_d;

    logic [1279:0]  chave_exp;
    logic [127:0]   miolo_out;
    logic [127:0]   final_out;

    expandeChave u_expande (
        .chave_i          (chave_q),
        .chaveExpandida_o (chave_exp)
    );

    mioloCifraBloco u_miolo (
        .estado_i         (estado_q),
        .chaveExpandida_i (chave_exp),
        .rodada_i         (rodada_q),
        .estado_o         (miolo_out)
    );

    rodada_final u_final (
        .estado_i (estado_q),
        .chave_i  (chave_rodada(chave_exp, 4'd10)),
        .estado_o (final_out)
    );

    assign ent_ready    = (fsm_q == OCIOSO);
    assign ocupado      = (fsm_q == RODADA) || (fsm_q == FINAL);
    assign sai_valid    = sai_valid_q;
    assign saida        = saida_q;
    assign rodada_atual = rodada_q;

    always_comb begin
        fsm_d       = fsm_q;
        estado_d    = estado_q;
        chave_d     = chave_q;
        saida_d     = saida_q;
        sai_valid_d = sai_valid_q;
        rodada_d    = rodada_q;

        case (fsm_q)
            OCIOSO: begin
                if (ent_valid && !cancela) begin
                    estado_d = bloco ^ chave;
                    chave_d  = chave;
                    rodada_d = 4'd1;
                    fsm_d    = RODADA;
                end
            end
            RODADA: begin
                estado_d = miolo_out;
                rodada_d = rodada_q + 4'd1;
                // The 9th middle round hands over to the final round.
                if (rodada_q >= 4'd9) begin
                    rodada_d = 4'd10;
                    fsm_d    = FINAL;
                end
            end
            FINAL: begin
                estado_d    = final_out;
                saida_d     = final_out;
                sai_valid_d = 1'b1;
                fsm_d       = SAIDA;
            end
            SAIDA: begin
                if (sai_ready) begin
                    sai_valid_d = 1'b0;
                    rodada_d    = 4'd0;
                    fsm_d       = OCIOSO;
                end
            end
            default: begin
                sai_valid_d = 1'b0;
                rodada_d    = 4'd0;
                fsm_d       = OCIOSO;
            end
        endcase

        // Abort wins over every transition; the last ciphertext stays on saida.
        if (cancela && fsm_q != OCIOSO) begin
            estado_d    = estado_q;
            sai_valid_d = 1'b0;
            rodada_d    = 4'd0;
            fsm_d       = OCIOSO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= OCIOSO;
            estado_q    <= '0;
            chave_q     <= '0;
            saida_q     <= '0;
            sai_valid_q <= 1'b0;
            rodada_q    <= 4'd0;
        end else begin
            fsm_q       <= fsm_d;
            estado_q    <= estado_d;
            chave_q     <= chave_d;
            saida_q     <= saida_d;
            sai_valid_q <= sai_valid_d;
            rodada_q    <= rodada_d;
        end
    end

endmodule

// File: tb/tb_controle_cifra_iterativa.sv
// Self-checking bench for controle_cifra_iterativa: FIPS-197 vectors, backpressure,
// abort and asynchronous reset, checked every cycle against a timing/AES model.
module tb_controle_cifra_iterativa;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ent_valid = 1'b0;
    logic         cancela = 1'b0;
    logic         sai_ready = 1'b1;
    logic [127:0] bloco = '0;
    logic [127:0] chave = '0;
    logic         ent_ready;
    logic         sai_valid;
    logic         ocupado;
    logic [127:0] saida;
    logic [3:0]   rodada_atual;

    localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_P  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_C  = 128'h3925841d02dc09fbdc118597196a0b32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    controle_cifra_iterativa #(.NRODADAS(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ent_valid    (ent_valid),
        .ent_ready    (ent_ready),
        .bloco        (bloco),
        .chave        (chave),
        .cancela      (cancela),
        .sai_valid    (sai_valid),
        .sai_ready    (sai_ready),
        .saida        (saida),
        .ocupado      (ocupado),
        .rodada_atual (rodada_atual)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference AES built from field arithmetic rather than lookup tables.
    logic [7:0] tb_sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, a;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
            end
            tb_sbox[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    // State after nr rounds (nr = 0 is just the initial AddRoundKey).
    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key,
                                               input int nr);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {tb_sbox[tmp[31:24]], tb_sbox[tmp[23:16]],
                       tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]]} ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = tb_sbox[s[(i + 4*(i%4)) % 16]];
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) begin
                    if (r < 10)
                        s[4*c+j] = gmul(t[4*c+j], 8'h02) ^ gmul(t[4*c+(j+1)%4], 8'h03)
                                 ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
                    else
                        s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Transaction model: 0 idle, 1 computing (m_k cycles since acceptance), 2 holding result.
    int           m_mode = 0;
    int           m_k = 0;
    logic [127:0] m_pt = '0;
    logic [127:0] m_key = '0;
    logic [127:0] m_cipher = '0;
    logic [127:0] m_saida = '0;

    always @(posedge clk) begin
        logic [3:0] exp_r;
        if (!rst_n) begin
            m_mode  = 0;
            m_saida = '0;
        end else begin
            case (m_mode)
                0: if (ent_valid && !cancela) begin
                    m_mode   = 1;
                    m_k      = 0;
                    m_pt     = bloco;
                    m_key    = chave;
                    m_cipher = aes_model(bloco, chave, 10);
                end
                1: if (cancela) m_mode = 0;
                   else begin
                       m_k++;
                       if (m_k == 10) begin
                           m_mode  = 2;
                           m_saida = m_cipher;
                       end
                   end
                default: if (cancela || sai_ready) m_mode = 0;
            endcase
        end
        #1;
        if (rst_n) begin
            exp_r = (m_mode == 0) ? 4'd0 : (m_mode == 1) ? 4'(m_k + 1) : 4'd10;
            chk("ent_ready", 128'(ent_ready), 128'(m_mode == 0));
            chk("sai_valid", 128'(sai_valid), 128'(m_mode == 2));
            chk("ocupado", 128'(ocupado), 128'(m_mode == 1));
            chk("rodada_atual", 128'(rodada_atual), 128'(exp_r));
            chk("saida", saida, m_saida);
            if (m_mode == 1) chk("estado_rodada", dut.estado_q, aes_model(m_pt, m_key, m_k));
        end
    end

    // Callers sit just after a falling edge; returns just after the accepting edge.
    task automatic send(input logic [127:0] pt, input logic [127:0] k);
        int n;
        ent_valid = 1'b1;
        bloco     = pt;
        chave     = k;
        n = 0;
        while (!ent_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 128'(n), 128'(0));
        @(negedge clk);
        ent_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!sai_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("valid_timeout", 128'(n), 128'(10));
    endtask

    initial begin
        int lat;
        build_sbox();
        chk("model_c1", aes_model(C1_P, C1_K, 10), C1_C);
        chk("model_b", aes_model(B_P, B_K, 10), B_C);

        repeat (3) @(negedge clk);
        chk("rst_ent_ready", 128'(ent_ready), 128'(1'b1));
        chk("rst_sai_valid", 128'(sai_valid), 128'(1'b0));
        chk("rst_saida", saida, 128'h0);
        chk("rst_rodada", 128'(rodada_atual), 128'(4'd0));
        rst_n = 1'b1;
        @(negedge clk);

        // C.1 then B back to back, consumer always ready; B is held during C.1.
        sai_ready = 1'b1;
        send(C1_P, C1_K);
        wait_valid(lat);
        chk("latencia_c1", 128'(lat), 128'(10));
        chk("saida_c1", saida, C1_C);
        send(B_P, B_K);
        wait_valid(lat);
        chk("latencia_b", 128'(lat), 128'(10));
        chk("saida_b", saida, B_C);
        @(negedge clk);

        // Backpressure: hold the result for five cycles.
        sai_ready = 1'b0;
        send(B_P, B_K);
        wait_valid(lat);
        repeat (5) @(negedge clk);
        chk("bp_saida", saida, B_C);
        chk("bp_ent_ready", 128'(ent_ready), 128'(1'b0));
        sai_ready = 1'b1;
        @(negedge clk);
        chk("bp_ent_ready_after", 128'(ent_ready), 128'(1'b1));
        chk("bp_sai_valid_after", 128'(sai_valid), 128'(1'b0));

        // cancela in idle blocks acceptance.
        ent_valid = 1'b1;
        cancela   = 1'b1;
        bloco     = C1_P;
        chave     = C1_K;
        @(negedge clk);
        ent_valid = 1'b0;
        cancela   = 1'b0;
        chk("cancel_idle_ocupado", 128'(ocupado), 128'(1'b0));

        // Abort during round 4, then a fresh block still encrypts correctly.
        send(B_P, B_K);
        repeat (3) @(negedge clk);
        chk("cancel_rodada4", 128'(rodada_atual), 128'(4'd4));
        cancela = 1'b1;
        @(negedge clk);
        cancela = 1'b0;
        chk("cancel_rodada", 128'(rodada_atual), 128'(4'd0));
        chk("cancel_ocupado", 128'(ocupado), 128'(1'b0));
        chk("cancel_saida_kept", saida, B_C);
        repeat (12) @(negedge clk);
        send(C1_P, C1_K);
        wait_valid(lat);
        chk("saida_c1_pos_cancel", saida, C1_C);
        @(negedge clk);

        // Asynchronous reset in the middle of round 6.
        send(B_P, B_K);
        repeat (5) @(negedge clk);
        chk("rst_rodada6", 128'(rodada_atual), 128'(4'd6));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ent_ready", 128'(ent_ready), 128'(1'b1));
        chk("arst_sai_valid", 128'(sai_valid), 128'(1'b0));
        chk("arst_saida", saida, 128'h0);
        chk("arst_ocupado", 128'(ocupado), 128'(1'b0));
        chk("arst_rodada", 128'(rodada_atual), 128'(4'd0));
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_ent_ready_after", 128'(ent_ready), 128'(1'b1));
        repeat (15) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
